uart_rx_ctrl: RTL and testbench

- UART receive sequencer driven by the 16x oversampling tick from the baud-rate generator.
- Synchronises the serial line, validates the start bit at mid-bit, samples DATA_BITS data bits LSB-first and checks the stop bit.
- Presents each received word on a one-entry valid/ready output with framing-error and overrun flags.
- Sits between the baud-rate generator/pin and the downstream byte consumer (FIFO or command parser).

---
 rtl/uart_rx_ctrl.sv | 131 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: oversampled start/data/stop framing feeding a one-entry
// valid/ready holding register, with framing-error and overrun pulses.
module uart_rx_ctrl #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_in,
    input  logic                 rx,
    input  logic                 data_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_t;

    state_t                state;
    logic [TICK_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0]  shift;
    logic                  rx_meta;
    logic                  rx_s;
    logic                  frame_good;

    // Good frame completes on the stop-sample tick with the line high.
    assign frame_good = tick_in && (state == StStop) && (tick_cnt == FULL_LAST) && rx_s;
    assign busy       = (state != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_meta     <= rx;
            rx_s        <= rx_meta;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;

            if (tick_in) begin
                unique case (state)
                    StIdle: begin
                        if (!rx_s) begin
                            state    <= StStart;
                            tick_cnt <= '0;
                        end
                    end
                    StStart: begin
                        if (tick_cnt == HALF_LAST) begin
                            if (!rx_s) begin
                                state    <= StData;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end else begin
                                state <= StIdle;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    StData: begin
                        if (tick_cnt == FULL_LAST) begin
                            shift    <= {rx_s, shift[DATA_BITS-1:1]};
                            tick_cnt <= '0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= StStop;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    StStop: begin
                        if (tick_cnt == FULL_LAST) begin
                            if (rx_s) begin
                                state <= StIdle;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= StBreak;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    StBreak: begin
                        // Wait out a held-low line so it cannot look like a new start bit.
                        if (rx_s) begin
                            state <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end

            if (frame_good) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shift;
                    data_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: table of whole frames plus hand-written
// glitch, framing-error, reset and tick-gating sequences.
module tb_uart_rx_ctrl;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned TICK_DIV   = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 tick_in;
    logic                 rx;
    logic                 data_ready;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 busy;
    logic                 tick_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int fe_cnt  = 0;
    int ov_cnt  = 0;
    int fe0;
    int ov0;

    typedef struct {
        logic [7:0] data;
        logic       rdy_at_stop;
        logic       consume;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         exp_ov;
    } vec_t;

    vec_t vecs[5];

    uart_rx_ctrl #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .rx         (rx),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin : tick_gen
        int div;
        div     = 0;
        tick_in = 1'b0;
        forever begin
            @(negedge clk);
            tick_in = tick_en && (div == TICK_DIV - 1);
            div     = (div == TICK_DIV - 1) ? 0 : div + 1;
        end
    end

    always @(negedge clk) begin
        if (frame_err)   fe_cnt++;
        if (overrun_err) ov_cnt++;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        @(posedge clk);
        while (!tick_in) @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(OVERSAMPLE);
    endtask

    task automatic consume();
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
    endtask

    // Optionally holds data_ready for exactly the stop-sample tick cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic rdy_at_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        rx = stop;
        wait_ticks(OVERSAMPLE / 2);
        if (rdy_at_stop) begin
            do begin
                @(negedge clk);
                #1;
            end while (!tick_in);
            data_ready = 1'b1;
            @(posedge clk);
            #1;
            data_ready = 1'b0;
            wait_ticks(OVERSAMPLE / 2 - 1);
        end else begin
            wait_ticks(OVERSAMPLE / 2);
        end
    endtask

    initial begin : main
        logic [7:0] d;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 0};
        vecs[1] = '{8'h11, 1'b0, 1'b0, 8'h11, 1'b1, 0};
        vecs[2] = '{8'h22, 1'b0, 1'b1, 8'h11, 1'b1, 1};
        vecs[3] = '{8'h11, 1'b0, 1'b0, 8'h11, 1'b1, 0};
        vecs[4] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 0};

        rst        = 1'b1;
        rx         = 1'b1;
        data_ready = 1'b0;
        #1;
        chk("reset data_out", data_out, 0);
        chk("reset data_valid", data_valid, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset overrun_err", overrun_err, 0);
        chk("reset busy", busy, 0);
        repeat (5) @(negedge clk);
        rst     = 1'b0;
        tick_en = 1'b1;
        wait_ticks(3);

        for (int i = 0; i < 5; i++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            send_frame(vecs[i].data, 1'b1, vecs[i].rdy_at_stop);
            chk($sformatf("vec%0d data_out", i), data_out, vecs[i].exp_data);
            chk($sformatf("vec%0d data_valid", i), data_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d overrun pulses", i), ov_cnt - ov0, vecs[i].exp_ov);
            chk($sformatf("vec%0d frame_err pulses", i), fe_cnt - fe0, 0);
            chk($sformatf("vec%0d busy", i), busy, 0);
            if (vecs[i].consume) begin
                consume();
                chk($sformatf("vec%0d valid after consume", i), data_valid, 0);
                chk($sformatf("vec%0d data held after consume", i), data_out, vecs[i].exp_data);
            end
        end

        // Short low glitch: rejected at the mid-start check.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx  = 1'b0;
        wait_ticks(3);
        chk("glitch busy during start", busy, 1);
        rx = 1'b1;
        wait_ticks(10);
        chk("glitch busy after", busy, 0);
        chk("glitch data_valid", data_valid, 0);
        chk("glitch frame_err", fe_cnt - fe0, 0);
        chk("glitch overrun", ov_cnt - ov0, 0);

        // Framing error followed by a long break, then a clean frame.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(40);
        chk("break busy", busy, 1);
        chk("break data_valid", data_valid, 0);
        chk("break frame_err pulses", fe_cnt - fe0, 1);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("break busy before tick", busy, 1);
        wait_tick();
        chk("break busy after tick", busy, 0);
        send_frame(8'h5A, 1'b1, 1'b0);
        chk("after break data_out", data_out, 8'h5A);
        chk("after break data_valid", data_valid, 1);
        chk("after break frame_err pulses", fe_cnt - fe0, 1);
        chk("after break overrun", ov_cnt - ov0, 0);

        // Reset in the middle of bit 4 of 0x7E while 0x5A is still held.
        d = 8'h7E;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        wait_ticks(OVERSAMPLE / 2);
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        chk("midreset data_out", data_out, 0);
        chk("midreset data_valid", data_valid, 0);
        chk("midreset busy", busy, 0);
        chk("midreset frame_err", frame_err, 0);
        chk("midreset overrun_err", overrun_err, 0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        wait_ticks(4);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'h81, 1'b1, 1'b0);
        chk("post-reset data_out", data_out, 8'h81);
        chk("post-reset data_valid", data_valid, 1);
        chk("post-reset frame_err", fe_cnt - fe0, 0);
        chk("post-reset overrun", ov_cnt - ov0, 0);
        consume();
        chk("post-reset consumed", data_valid, 0);

        // Tick stream stalled for 500 clk in the middle of bit 3 of 0xC3.
        d   = 8'hC3;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        rx = d[3];
        wait_ticks(5);
        tick_en = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        chk("gated busy held", busy, 1);
        chk("gated data_valid held", data_valid, 0);
        tick_en = 1'b1;
        wait_ticks(OVERSAMPLE - 5);
        for (int i = 4; i < 8; i++) send_bit(d[i]);
        send_bit(1'b1);
        chk("gated data_out", data_out, 8'hC3);
        chk("gated data_valid", data_valid, 1);
        chk("gated frame_err", fe_cnt - fe0, 0);
        chk("gated overrun", ov_cnt - ov0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
